// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and drives the imem req/ack port.
// Feeds Decode from a valid/ready hold buffer, with branch redirect and halt.
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC_out,
  input  logic        dec_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [31:0] PC_INIT = {PC_RESET[31:1], 1'b0};

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_tgt, w_tgt;
  logic        r_pend, w_pend;
  logic [15:0] r_instr, w_instr;
  logic [31:0] r_pc_out, w_pc_out;
  logic [31:0] r_cnt, w_cnt;
  logic [31:0] w_br_tgt;
  logic        w_unused_bits;

  assign w_br_tgt      = {branch_target[31:1], 1'b0};
  assign w_unused_bits = branch_target[0];

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_tgt    = r_tgt;
    w_pend   = r_pend;
    w_instr  = r_instr;
    w_pc_out = r_pc_out;
    w_cnt    = r_cnt;
    unique case (r_state)
      S_BOOT: w_state = S_FETCH;
      S_FETCH: begin
        if (halt) begin
          w_state = imem_ack ? S_HALTED : S_DRAIN;
        end else if (imem_ack && (branch_taken || r_pend)) begin
          // Stale data from before a redirect is dropped
          w_pc   = branch_taken ? w_br_tgt : r_tgt;
          w_pend = 1'b0;
        end else if (imem_ack) begin
          w_instr  = imem_rdata;
          w_pc_out = r_pc;
          w_pc     = r_pc + 32'd2;
          w_state  = S_HOLD;
        end else if (branch_taken) begin
          w_tgt  = w_br_tgt;
          w_pend = 1'b1;
        end
      end
      S_HOLD: begin
        if (halt) begin
          w_state = S_HALTED;
        end else if (branch_taken) begin
          w_pc    = w_br_tgt;
          w_pend  = 1'b0;
          w_state = S_FETCH;
        end else if (dec_ready) begin
          w_cnt   = r_cnt + 32'd1;
          w_state = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_ack) w_state = S_HALTED;
      end
      S_HALTED: w_state = S_HALTED;
      default:  w_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_pc     <= PC_INIT;
      r_tgt    <= '0;
      r_pend   <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_cnt    <= RETIRED_INIT;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_tgt    <= w_tgt;
      r_pend   <= w_pend;
      r_instr  <= w_instr;
      r_pc_out <= w_pc_out;
      r_cnt    <= w_cnt;
    end
  end

  assign imem_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr   = imem_req ? r_pc : '0;
  assign instr_valid = (r_state == S_HOLD);
  assign halted      = (r_state == S_HALTED);
  assign instr       = r_instr;
  assign PC_out      = r_pc_out;
  assign retired_cnt = r_cnt;

endmodule
